// File: rtl/mode_sequencer.sv
// mode_sequencer: debounces the panel buttons, browses/enters playable modes with a
// guarded hand-over, and muxes the active mode's buzzer line onto signal.
module mode_sequencer #(
   parameter int NUM_MODES       = 4,
   parameter int MODE_W          = $clog2(NUM_MODES),
   parameter int DEBOUNCE_CYCLES = 2000000,
   parameter int GUARD_CYCLES    = 1000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 btn_next,
   input  logic                 btn_enter,
   input  logic                 btn_back,
   input  logic [NUM_MODES-1:0] mode_sig,
   output logic [MODE_W-1:0]    mode,
   output logic [MODE_W-1:0]    cursor,
   output logic [NUM_MODES-1:0] mode_en,
   output logic                 busy,
   output logic                 signal
);
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
   localparam int GD_W = $clog2(GUARD_CYCLES + 1);
   typedef enum logic [1:0] {MENU, GUARD, ACTIVE} state_t;
   state_t                r_state;
   logic [2:0]            w_raw, w_press;
   logic [2:0]            r_s1, r_s2;
   logic [MODE_W-1:0]     r_mode, r_cursor, r_target, w_cur_nxt;
   logic [GD_W-1:0]       r_gcnt;
   logic [NUM_MODES-1:0]  r_en, w_onehot;
   logic                  r_busy, r_signal;
   assign w_raw     = {btn_back, btn_enter, btn_next};
   assign w_cur_nxt = (r_cursor == MODE_W'(NUM_MODES - 1)) ? MODE_W'(1) : r_cursor + MODE_W'(1);
   assign w_onehot  = NUM_MODES'(1) << r_target;
   assign mode      = r_mode;
   assign cursor    = r_cursor;
   assign mode_en   = r_en;
   assign busy      = r_busy;
   assign signal    = r_signal;
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= w_raw;
         r_s2 <= r_s1;
      end
   end
   // press fires on the same edge the accepted level rises, so the FSM reacts one edge later
   for (genvar b = 0; b < 3; b++) begin : g_db
      logic [DB_W-1:0] r_cnt;
      logic            r_acc, r_press;
      always_ff @(posedge clk) begin
         if (!rst) begin
            r_cnt   <= '0;
            r_acc   <= 1'b0;
            r_press <= 1'b0;
         end else begin
            r_press <= 1'b0;
            if (r_s2[b] == r_acc) r_cnt <= '0;
            else if (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               r_cnt   <= '0;
               r_acc   <= r_s2[b];
               r_press <= r_s2[b];
            end else r_cnt <= r_cnt + DB_W'(1);
         end
      end
      assign w_press[b] = r_press;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= MENU;
         r_mode   <= '0;
         r_cursor <= MODE_W'(1);
         r_target <= '0;
         r_gcnt   <= '0;
         r_en     <= '0;
         r_busy   <= 1'b0;
         r_signal <= 1'b0;
      end else begin
         case (r_state)
            MENU: begin
               r_signal <= 1'b0;
               if (!w_press[2]) begin
                  if (w_press[1]) begin
                     r_target <= r_cursor;
                     r_state  <= GUARD;
                     r_busy   <= 1'b1;
                     r_gcnt   <= '0;
                  end else if (w_press[0]) r_cursor <= w_cur_nxt;
               end
            end
            GUARD: begin
               if (r_gcnt == GD_W'(GUARD_CYCLES - 1)) begin
                  r_state <= (r_target == '0) ? MENU : ACTIVE;
                  r_mode  <= r_target;
                  r_en    <= (r_target == '0) ? '0 : w_onehot;
                  r_busy  <= 1'b0;
               end else r_gcnt <= r_gcnt + GD_W'(1);
            end
            ACTIVE: begin
               r_signal <= mode_sig[r_mode];
               if (w_press[2]) begin
                  r_target <= '0;
                  r_state  <= GUARD;
                  r_busy   <= 1'b1;
                  r_gcnt   <= '0;
                  r_en     <= '0;
                  r_signal <= 1'b0;
               end else if (!w_press[1] && w_press[0]) r_cursor <= w_cur_nxt;
            end
            default: r_state <= MENU;
         endcase
      end
   end
endmodule

// File: tb/tb_mode_sequencer.sv
// tb_mode_sequencer: directed scoreboard bench for mode_sequencer (4 modes, debounce 4, guard 3).
module tb_mode_sequencer;
   localparam int N = 4;
   logic clk = 1'b0;
   logic rst, btn_next, btn_enter, btn_back;
   logic [N-1:0] mode_sig;
   logic [1:0]   mode, cursor;
   logic [N-1:0] mode_en;
   logic         busy, signal;
   typedef enum int {F_MODE, F_CURSOR, F_EN, F_BUSY, F_SIG} field_t;
   typedef struct {
      string       tag;
      field_t      f;
      logic [31:0] exp;
   } item_t;
   item_t sb[$];
   int checks = 0;
   int errors = 0;
   mode_sequencer #(.NUM_MODES(N), .DEBOUNCE_CYCLES(4), .GUARD_CYCLES(3)) dut (
      .clk(clk), .rst(rst), .btn_next(btn_next), .btn_enter(btn_enter), .btn_back(btn_back),
      .mode_sig(mode_sig), .mode(mode), .cursor(cursor), .mode_en(mode_en), .busy(busy),
      .signal(signal)
   );
   always #5 clk = ~clk;
   function automatic logic [31:0] obs(field_t f);
      return f == F_MODE ? 32'(mode) : f == F_CURSOR ? 32'(cursor) : f == F_EN ? 32'(mode_en) :
             f == F_BUSY ? 32'(busy) : 32'(signal);
   endfunction
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic want(input string tag, input field_t f, input logic [31:0] v);
      sb.push_back('{tag, f, v});
   endtask
   task automatic drain();
      item_t it;
      logic [31:0] o;
      while (sb.size() > 0) begin
         it = sb.pop_front();
         o = obs(it.f);
         checks++;
         assert (o === it.exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", it.tag, o, it.exp);
         end
      end
   endtask
   task automatic press(input logic [2:0] m);
      {btn_back, btn_enter, btn_next} = m;
      tick(7);
      {btn_back, btn_enter, btn_next} = 3'b000;
      tick(8);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      rst = 1'b0; btn_next = 1'b0; btn_enter = 1'b0; btn_back = 1'b0; mode_sig = '0;
      tick(2);
      rst = 1'b1;
      want("rst_mode", F_MODE, 0); want("rst_cursor", F_CURSOR, 1); want("rst_en", F_EN, 0);
      want("rst_sig", F_SIG, 0); want("rst_busy", F_BUSY, 0);
      drain();
      // bouncing next: only the final stable high counts
      btn_next = 1'b1; tick(1); btn_next = 1'b0; tick(1);
      btn_next = 1'b1; tick(1); btn_next = 1'b0; tick(1);
      btn_next = 1'b1; tick(6);
      want("db_early", F_CURSOR, 1); drain();
      tick(1);
      want("db_accept", F_CURSOR, 2); drain();
      btn_next = 1'b0; tick(8);
      want("db_release", F_CURSOR, 2); drain();
      btn_next = 1'b1; tick(3); btn_next = 1'b0; tick(10);
      want("glitch", F_CURSOR, 2); drain();
      press(3'b001); want("wrap_a", F_CURSOR, 3); want("wrap_a_mode", F_MODE, 0); drain();
      press(3'b001); want("wrap_b", F_CURSOR, 1); want("wrap_b_mode", F_MODE, 0); drain();
      press(3'b001); want("wrap_c", F_CURSOR, 2); want("wrap_c_en", F_EN, 0); drain();
      btn_enter = 1'b1; tick(7);
      want("g1_busy", F_BUSY, 1); want("g1_en", F_EN, 0); want("g1_mode", F_MODE, 0); drain();
      tick(1); want("g2_busy", F_BUSY, 1); want("g2_en", F_EN, 0); drain();
      tick(1); want("g3_busy", F_BUSY, 1); want("g3_en", F_EN, 0); drain();
      tick(1); want("act_busy", F_BUSY, 0); want("act_mode", F_MODE, 2); want("act_en", F_EN, 4'b0100); drain();
      btn_enter = 1'b0; tick(8);
      want("act_sig0", F_SIG, 0); drain();
      mode_sig = 4'b0100;
      want("sig_lat", F_SIG, 0); drain();
      tick(1); want("sig_on", F_SIG, 1); drain();
      mode_sig = 4'b1010;
      tick(1); want("sig_off", F_SIG, 0); drain();
      tick(1); want("sig_other", F_SIG, 0); drain();
      mode_sig = 4'b0100;
      press(3'b001);
      want("act_next_cur", F_CURSOR, 3); want("act_next_mode", F_MODE, 2);
      want("act_next_en", F_EN, 4'b0100); want("act_next_sig", F_SIG, 1); drain();
      // back+enter together, then a next pulse landing inside GUARD
      btn_back = 1'b1; btn_enter = 1'b1; tick(1);
      btn_next = 1'b1; tick(6);
      want("bk_busy", F_BUSY, 1); want("bk_en", F_EN, 0); want("bk_sig", F_SIG, 0); want("bk_mode", F_MODE, 2); drain();
      tick(1); want("bk_g2_cur", F_CURSOR, 3); want("bk_g2_busy", F_BUSY, 1); drain();
      tick(1); want("bk_g3_busy", F_BUSY, 1); drain();
      tick(1);
      want("bk_exit_busy", F_BUSY, 0); want("bk_exit_mode", F_MODE, 0); want("bk_exit_en", F_EN, 0);
      want("bk_exit_sig", F_SIG, 0); want("bk_exit_cur", F_CURSOR, 3); drain();
      {btn_back, btn_enter, btn_next} = 3'b000; tick(8);
      want("menu_cur", F_CURSOR, 3); want("menu_mode", F_MODE, 0); drain();
      btn_enter = 1'b1; tick(7);
      want("rg1_busy", F_BUSY, 1); drain();
      tick(1); want("rg2_busy", F_BUSY, 1); drain();
      rst = 1'b0; btn_enter = 1'b0; tick(1);
      want("rg_mode", F_MODE, 0); want("rg_busy", F_BUSY, 0); want("rg_cur", F_CURSOR, 1); want("rg_en", F_EN, 0); drain();
      rst = 1'b1; tick(4);
      want("post_busy", F_BUSY, 0); want("post_mode", F_MODE, 0); want("post_en", F_EN, 0); drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
